// File: rtl/decode_mc.sv
// Multicycle control unit for the ARM-subset core: main FSM, ALU decoder and PC logic,
// with variable-latency execute (wait counter + start strobe) and a second long-multiply writeback.
module decode_mc #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 16,
  parameter int FP_CYCLES  = 4,
  parameter int CNT_W      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] IsMul,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       PCS,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] FlagW,
  output logic [3:0] ALUControl,
  output logic [3:0] state,
  output logic       noWrite,
  output logic       opMul,
  output logic       IsLongMul,
  output logic       ExStart,
  output logic       ExBusy,
  output logic       WrHi
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_EXWAIT   = 4'd10;
  localparam logic [3:0] S_ALUWB2   = 4'd11;

  logic [3:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       alu_raw;
  int               lat;
  logic             multi;
  logic             branch;
  logic             final_ex;

  // ALU op is decoded independently of ALUOp so latency and long-mul status stay valid in every state.
  always_comb begin
    opMul = (Op == 2'b00) && (Funct[5:4] == 2'b00) && (IsMul == 4'b1001);
    noWrite = (Funct[4:1] == 4'b1010);
    alu_raw = 4'b0000;
    case (Funct[4:1])
      4'b0000:          alu_raw = opMul ? 4'b0100 : 4'b0010;
      4'b0001:          alu_raw = 4'b1000;
      4'b0010, 4'b1010: alu_raw = 4'b0001;
      4'b0011:          alu_raw = 4'b1001;
      4'b0100:          alu_raw = opMul ? 4'b0101 : 4'b0000;
      4'b0101:          alu_raw = 4'b1010;
      4'b0110:          alu_raw = 4'b0110;
      4'b0111:          alu_raw = 4'b1011;
      4'b1100:          alu_raw = 4'b0011;
      4'b1101:          alu_raw = 4'b1100;
      4'b1111:          alu_raw = 4'b0111;
      default:          alu_raw = 4'b0000;
    endcase
    lat = 1;
    case (alu_raw)
      4'b0100, 4'b0101, 4'b0110:          lat = MUL_CYCLES;
      4'b0111:                            lat = DIV_CYCLES;
      4'b1000, 4'b1001, 4'b1010, 4'b1011: lat = FP_CYCLES;
      default:                            lat = 1;
    endcase
    multi = (lat > 1);
    IsLongMul = opMul && ((alu_raw == 4'b0101) || (alu_raw == 4'b0110));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = S_FETCH;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        if (Op == 2'b01)                 state_next = S_MEMADR;
        else if (Op == 2'b10)            state_next = S_BRANCH;
        else if (Op == 2'b00 && Funct[5]) state_next = S_EXECUTEI;
        else                             state_next = S_EXECUTER;
      end
      S_MEMADR: state_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next = S_MEMWB;
      S_EXECUTER, S_EXECUTEI: begin
        if (multi) begin
          // First execute cycle is this one; the last is the EXWAIT cycle that sees cnt==0.
          cnt_next   = CNT_W'(lat - 2);
          state_next = S_EXWAIT;
        end else begin
          state_next = noWrite ? S_FETCH : S_ALUWB;
        end
      end
      S_EXWAIT: begin
        if (cnt_reg != '0) begin
          cnt_next   = cnt_reg - 1'b1;
          state_next = S_EXWAIT;
        end else begin
          state_next = noWrite ? S_FETCH : S_ALUWB;
        end
      end
      S_ALUWB:  state_next = IsLongMul ? S_ALUWB2 : S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  always_comb begin
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    NextPC     = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    FlagW      = 2'b00;
    ALUControl = 4'b0000;
    ExStart    = 1'b0;
    ExBusy     = 1'b0;
    WrHi       = 1'b0;
    branch     = 1'b0;
    final_ex   = 1'b0;
    case (state_reg)
      S_FETCH: begin
        IRWrite = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; NextPC = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWR:  begin AdrSrc = 1'b1; MemW = 1'b1; end
      S_MEMWB:  begin ResultSrc = 2'b01; RegW = 1'b1; end
      S_EXECUTER, S_EXECUTEI: begin
        ALUSrcB    = (state_reg == S_EXECUTEI) ? 2'b01 : 2'b00;
        ALUControl = alu_raw;
        ExStart    = multi;
        final_ex   = !multi;
      end
      S_EXWAIT: begin
        ALUSrcB    = (Op == 2'b00 && Funct[5]) ? 2'b01 : 2'b00;
        ALUControl = alu_raw;
        ExBusy     = 1'b1;
        final_ex   = (cnt_reg == '0);
      end
      S_ALUWB:  RegW = 1'b1;
      S_ALUWB2: begin RegW = 1'b1; WrHi = 1'b1; end
      S_BRANCH: begin ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1; end
      default: ;
    endcase
    if (final_ex)
      FlagW = {Funct[0], Funct[0] && ((alu_raw == 4'b0000) || (alu_raw == 4'b0001) || (alu_raw == 4'b0100))};
    if (reset) begin
      IRWrite = 1'b0; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0;
      ExStart = 1'b0; branch = 1'b0; FlagW = 2'b00;
    end
    PCS = ((Rd == 4'b1111) && RegW && !WrHi) || branch;
  end

  assign ImmSrc = Op;
  assign RegSrc = {Op == 2'b01, Op == 2'b10};
  assign state  = state_reg;

endmodule

// File: tb/tb_decode_mc.sv
// Directed bench for decode_mc: walks each instruction class through the FSM and checks controls.
module tb_decode_mc;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] IsMul;
  logic       IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, PCS;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, FlagW;
  logic [3:0] ALUControl, state;
  logic       noWrite, opMul, IsLongMul, ExStart, ExBusy, WrHi;

  int total = 0;
  int bad   = 0;

  decode_mc #(.MUL_CYCLES(2), .DIV_CYCLES(16), .FP_CYCLES(4), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .IsMul(IsMul),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .NextPC(NextPC), .RegW(RegW),
    .MemW(MemW), .PCS(PCS), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .RegSrc(RegSrc), .FlagW(FlagW), .ALUControl(ALUControl), .state(state), .noWrite(noWrite),
    .opMul(opMul), .IsLongMul(IsLongMul), .ExStart(ExStart), .ExBusy(ExBusy), .WrHi(WrHi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_state(input string tag, input logic [3:0] exp);
    step();
    chk(tag, 32'(state), 32'(exp));
  endtask

  task automatic set_instr(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                           input logic [3:0] ism);
    Op = op; Funct = fn; Rd = rd; IsMul = ism;
  endtask

  initial begin
    reset = 1'b1;
    set_instr(2'b00, 6'b001000, 4'd1, 4'd0);
    step(); step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_irwrite", 32'(IRWrite), 32'd0);
    chk("rst_nextpc", 32'(NextPC), 32'd0);
    reset = 1'b0;
    #1;
    chk("fetch_irwrite", 32'(IRWrite), 32'd1);
    chk("fetch_nextpc", 32'(NextPC), 32'd1);
    $display("txn reset: state=%0d", state);

    // ADD r1,r2,r3
    step_state("add_dec", 4'd1);
    step_state("add_exr", 4'd6);
    chk("add_aluctl", 32'(ALUControl), 32'h0);
    chk("add_regw_ex", 32'(RegW), 32'd0);
    step_state("add_wb", 4'd8);
    chk("add_regw_wb", 32'(RegW), 32'd1);
    chk("add_pcs_wb", 32'(PCS), 32'd0);
    step_state("add_fetch", 4'd0);
    $display("txn ADD done");

    // DIV: 1 EXECUTER + 15 EXWAIT
    set_instr(2'b00, 6'b011110, 4'd3, 4'd0);
    step_state("div_dec", 4'd1);
    step_state("div_exr", 4'd6);
    chk("div_exstart", 32'(ExStart), 32'd1);
    chk("div_aluctl", 32'(ALUControl), 32'h7);
    for (int i = 0; i < 15; i++) begin
      step_state("div_wait", 4'd10);
      chk("div_busy", 32'(ExBusy), 32'd1);
      if (i == 0) chk("div_exstart_wait", 32'(ExStart), 32'd0);
      if (i == 5) chk("div_flagw_mid", 32'(FlagW), 32'd0);
    end
    step_state("div_wb", 4'd8);
    chk("div_regw", 32'(RegW), 32'd1);
    step_state("div_fetch", 4'd0);
    $display("txn DIV done");

    // UMULL S=1
    set_instr(2'b00, 6'b001001, 4'd2, 4'b1001);
    step_state("umull_dec", 4'd1);
    step_state("umull_exr", 4'd6);
    chk("umull_aluctl", 32'(ALUControl), 32'h5);
    chk("umull_long", 32'(IsLongMul), 32'd1);
    chk("umull_exstart", 32'(ExStart), 32'd1);
    chk("umull_flagw_ex", 32'(FlagW), 32'd0);
    step_state("umull_wait", 4'd10);
    chk("umull_flagw_wait", 32'(FlagW), 32'b10);
    step_state("umull_wb", 4'd8);
    chk("umull_wrhi_wb", 32'(WrHi), 32'd0);
    chk("umull_flagw_wb", 32'(FlagW), 32'd0);
    step_state("umull_wb2", 4'd11);
    chk("umull_wrhi_wb2", 32'(WrHi), 32'd1);
    chk("umull_regw_wb2", 32'(RegW), 32'd1);
    step_state("umull_fetch", 4'd0);
    $display("txn UMULL done");

    // CMP immediate
    set_instr(2'b00, 6'b110101, 4'd0, 4'd0);
    step_state("cmp_dec", 4'd1);
    step_state("cmp_exi", 4'd7);
    chk("cmp_flagw", 32'(FlagW), 32'b11);
    chk("cmp_aluctl", 32'(ALUControl), 32'h1);
    chk("cmp_srcb", 32'(ALUSrcB), 32'b01);
    chk("cmp_regw", 32'(RegW), 32'd0);
    chk("cmp_nowrite", 32'(noWrite), 32'd1);
    step_state("cmp_fetch", 4'd0);
    $display("txn CMP done");

    // LDR
    set_instr(2'b01, 6'b011001, 4'd4, 4'd0);
    step_state("ldr_dec", 4'd1);
    step_state("ldr_adr", 4'd2);
    chk("ldr_srcb", 32'(ALUSrcB), 32'b01);
    step_state("ldr_rd", 4'd3);
    chk("ldr_adrsrc", 32'(AdrSrc), 32'd1);
    step_state("ldr_wb", 4'd4);
    chk("ldr_regw", 32'(RegW), 32'd1);
    chk("ldr_ressrc", 32'(ResultSrc), 32'b01);
    chk("ldr_regsrc", 32'(RegSrc), 32'b10);
    step_state("ldr_fetch", 4'd0);
    $display("txn LDR done");

    // STR
    set_instr(2'b01, 6'b011000, 4'd4, 4'd0);
    step_state("str_dec", 4'd1);
    step_state("str_adr", 4'd2);
    step_state("str_wr", 4'd5);
    chk("str_memw", 32'(MemW), 32'd1);
    step_state("str_fetch", 4'd0);
    $display("txn STR done");

    // B
    set_instr(2'b10, 6'b100000, 4'd0, 4'd0);
    step_state("b_dec", 4'd1);
    step_state("b_br", 4'd9);
    chk("b_pcs", 32'(PCS), 32'd1);
    chk("b_immsrc", 32'(ImmSrc), 32'b10);
    step_state("b_fetch", 4'd0);
    $display("txn B done");

    // MOV pc
    set_instr(2'b00, 6'b011010, 4'hF, 4'd0);
    step_state("mov_dec", 4'd1);
    step_state("mov_exr", 4'd6);
    chk("mov_aluctl", 32'(ALUControl), 32'hC);
    step_state("mov_wb", 4'd8);
    chk("mov_pcs", 32'(PCS), 32'd1);
    step_state("mov_fetch", 4'd0);
    $display("txn MOV pc done");

    // Reset during 5th EXWAIT cycle of DIV
    set_instr(2'b00, 6'b011110, 4'd3, 4'd0);
    step_state("rdiv_dec", 4'd1);
    step_state("rdiv_exr", 4'd6);
    for (int i = 0; i < 5; i++) step_state("rdiv_wait", 4'd10);
    reset = 1'b1;
    #1;
    chk("rdiv_regw", 32'(RegW), 32'd0);
    chk("rdiv_flagw", 32'(FlagW), 32'd0);
    step_state("rdiv_fetch", 4'd0);
    chk("rdiv_exstart", 32'(ExStart), 32'd0);
    reset = 1'b0;
    set_instr(2'b00, 6'b001000, 4'd1, 4'd0);
    #1;
    chk("rdiv_irwrite", 32'(IRWrite), 32'd1);
    step_state("radd_dec", 4'd1);
    step_state("radd_exr", 4'd6);
    chk("radd_exstart", 32'(ExStart), 32'd0);
    step_state("radd_wb", 4'd8);
    chk("radd_regw", 32'(RegW), 32'd1);
    step_state("radd_fetch", 4'd0);
    $display("txn reset-abort + ADD done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
